uart_tx_param: RTL

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: small in-order FIFO feeding a start/data/parity/stop
// framer. Each frame latches its own configuration, so frames can run back-to-back.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (0) for one bit period
// DATA   | DATA_WIDTH data bits, LSB first
// PARITY | optional even/odd parity bit
// STOP   | one or two stop-bit periods (1)
module uart_tx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [DIV_WIDTH-1:0]          cfg_div_i,
    input  logic [1:0]                    cfg_parity_i,
    input  logic                          cfg_stop2_i,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata_i,
    input  logic                          s_axis_tvalid_i,
    output logic                          s_axis_tready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level;
    logic                  push, pop, fifo_nonempty;
    logic [DATA_WIDTH-1:0] head;

    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit, par_en, stop2_l;
    logic [DIV_WIDTH-1:0]  div_l, div_new;
    logic [DIV_WIDTH-1:0]  baud_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  bit_done, bit_last;
    logic                  shift_en, tx_nxt, tx_q;

    assign s_axis_tready_o = (level != LW'(FIFO_DEPTH));
    assign push            = s_axis_tvalid_i && s_axis_tready_o;
    assign fifo_nonempty   = (level != '0);
    assign head            = mem[rd_ptr];
    assign fifo_level_o    = level;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_tdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // A divider of 0 is treated as 1 so a bit is never shorter than two clocks.
    assign div_new  = (cfg_div_i == '0) ? DIV_WIDTH'(1) : cfg_div_i;
    assign bit_done = (baud_cnt == '0);
    assign bit_last = (bit_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (fifo_nonempty) state_nxt = S_START;
            S_START:  if (bit_done) state_nxt = S_DATA;
            S_DATA:   if (bit_done && bit_last) state_nxt = par_en ? S_PARITY : S_STOP;
            S_PARITY: if (bit_done) state_nxt = S_STOP;
            S_STOP:   if (bit_done && bit_last) state_nxt = fifo_nonempty ? S_START : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pop      = (state_nxt == S_START) && ((state == S_IDLE) || (state == S_STOP));
        shift_en = (state_nxt == S_DATA) && ((state == S_START) || bit_done);
        tx_nxt   = 1'b1;
        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = shift_en ? shreg[0] : tx_q;
            S_PARITY: tx_nxt = par_bit;
            default:  tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_q     <= 1'b1;
            shreg    <= '0;
            par_bit  <= 1'b0;
            par_en   <= 1'b0;
            stop2_l  <= 1'b0;
            div_l    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            tx_q <= tx_nxt;

            if (pop) begin
                shreg    <= head;
                par_bit  <= (^head) ^ (cfg_parity_i == 2'b10);
                par_en   <= (cfg_parity_i == 2'b01) || (cfg_parity_i == 2'b10);
                stop2_l  <= cfg_stop2_i;
                div_l    <= div_new;
            end else if (shift_en) begin
                shreg <= shreg >> 1;
            end

            if (pop) begin
                baud_cnt <= div_new;
            end else if (state_nxt == S_IDLE) begin
                baud_cnt <= '0;
            end else if (bit_done) begin
                baud_cnt <= div_l;
            end else begin
                baud_cnt <= baud_cnt - DIV_WIDTH'(1);
            end

            if (state != S_DATA && state_nxt == S_DATA) begin
                bit_cnt <= BW'(DATA_WIDTH - 1);
            end else if (state != S_STOP && state_nxt == S_STOP) begin
                bit_cnt <= BW'(stop2_l);
            end else if (state_nxt != state) begin
                bit_cnt <= '0;
            end else if (bit_done && !bit_last && (state == S_DATA || state == S_STOP)) begin
                bit_cnt <= bit_cnt - BW'(1);
            end
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = (state != S_IDLE);

endmodule
